uart_frame_bridge: RTL

Bridges a UART byte stream and the hardcaml puzzle core's word-level valid/ready interface. Received bytes are assembled into FRAME_BYTES-byte words and buffered in a DEPTH-entry FIFO, so frames are not lost while the core is busy. Core results are captured on the rising edge of result_valid and serialised back out as FRAME_BYTES bytes through a byte handshake. Sits between uart_top and aoc_top, replacing the ad-hoc frame glue in the FPGA top level.

---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_bridge_fifo.sv | 55 +++++
 rtl/uart_frame_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constant helpers for the UART frame bridge.
package uart_frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  function automatic int word_width(input int frame_bytes);
    return 8 * frame_bytes;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_frame_bridge_fifo.sv
// Word FIFO between the frame assembler and the core; head word is always visible.
module frame_word_fifo
  import uart_frame_pkg::*;
#(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int LVL_W = clog2(DEPTH + 1),
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             not_empty,
  output logic [LVL_W-1:0] level,
  output logic             drop
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign not_empty = (level_reg != '0);
  assign full      = (level_reg == LVL_W'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign do_push   = push && (!full || do_pop);
  assign drop      = push && full && !do_pop;
  assign head      = mem[rd_ptr_reg];
  assign level     = level_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop) level_reg <= level_reg + LVL_W'(1);
      else if (do_pop && !do_push) level_reg <= level_reg - LVL_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_bridge.sv
// Assembles UART bytes into core words (buffered) and serialises core results back to bytes.
module uart_frame_bridge
  import uart_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 8,
  parameter int DEPTH = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int W = word_width(FRAME_BYTES),
  localparam int LVL_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [W-1:0]     data_value,
  output logic             data_valid,
  input  logic             data_ready,
  input  logic [W-1:0]     result_value,
  input  logic             result_valid,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             rx_overflow,
  output logic             tx_overrun,
  output logic             rx_timeout
);

  localparam int IDX_W  = (clog2(FRAME_BYTES) < 1) ? 1 : clog2(FRAME_BYTES);
  localparam int IDLE_W = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [IDX_W-1:0]  byte_cnt_reg;
  logic [W-1:0]      asm_reg;
  logic [W-1:0]      asm_next;
  logic [IDLE_W-1:0] idle_reg;
  logic              frame_done;
  logic              timeout_fire;
  logic              fifo_drop;

  tx_state_t         state_reg, state_next;
  logic [W-1:0]      tx_shift_reg, tx_shift_next;
  logic [IDX_W-1:0]  tx_idx_reg, tx_idx_next;
  logic              result_valid_q;
  logic              result_edge;
  logic              overrun_set;
  logic [7:0]        tx_lane [FRAME_BYTES];

  // Lane gi is the gi-th byte on the wire; LSB_FIRST chooses where it sits in the word.
  for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_lane
    localparam int POS = LSB_FIRST ? gi : FRAME_BYTES - 1 - gi;
    assign asm_next[POS*8 +: 8] = (rx_valid && byte_cnt_reg == IDX_W'(gi)) ? rx_byte
                                                                           : asm_reg[POS*8 +: 8];
    assign tx_lane[gi] = tx_shift_reg[POS*8 +: 8];
  end

  assign frame_done   = rx_valid && (byte_cnt_reg == LAST_IDX);
  assign timeout_fire = (TIMEOUT_CYCLES > 0) && !rx_valid && (byte_cnt_reg != '0)
                        && (idle_reg == IDLE_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      idle_reg     <= '0;
      rx_timeout   <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      rx_timeout <= timeout_fire;
      if (fifo_drop) rx_overflow <= 1'b1;
      if (rx_valid) begin
        asm_reg      <= asm_next;
        byte_cnt_reg <= frame_done ? '0 : byte_cnt_reg + IDX_W'(1);
        idle_reg     <= '0;
      end else if (timeout_fire) begin
        byte_cnt_reg <= '0;
        idle_reg     <= '0;
      end else if (byte_cnt_reg != '0) begin
        idle_reg <= idle_reg + IDLE_W'(1);
      end else begin
        idle_reg <= '0;
      end
    end
  end

  frame_word_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (frame_done),
    .push_data (asm_next),
    .pop       (data_ready),
    .head      (data_value),
    .not_empty (data_valid),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign result_edge = result_valid && !result_valid_q;
  assign tx_valid    = (state_reg == SEND);
  assign tx_byte     = tx_lane[tx_idx_reg];

  always_comb begin
    state_next    = state_reg;
    tx_shift_next = tx_shift_reg;
    tx_idx_next   = tx_idx_reg;
    overrun_set   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (result_edge) begin
          state_next    = SEND;
          tx_shift_next = result_value;
          tx_idx_next   = '0;
        end
      end
      SEND: begin
        // Any new result while busy is dropped, including on the final handshake.
        overrun_set = result_edge;
        if (tx_ready) begin
          if (tx_idx_reg == LAST_IDX) state_next = IDLE;
          else tx_idx_next = tx_idx_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      tx_shift_reg   <= '0;
      tx_idx_reg     <= '0;
      result_valid_q <= 1'b0;
      tx_overrun     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tx_shift_reg   <= tx_shift_next;
      tx_idx_reg     <= tx_idx_next;
      result_valid_q <= result_valid;
      if (overrun_set) tx_overrun <= 1'b1;
    end
  end

endmodule
